// File: rtl/shift_sequencer_16bit.sv
// Multi-cycle sequencer wrapping a 4-bit-amount combinational barrel shifter.
// Optional SHIFT_SEQ_EARLY_ZERO_EN: amounts >= 16 complete in DONE without any shifter pass.
module shift_sequencer_16bit #(
  parameter int AMT_W = 6,
  parameter int CHUNK = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic [15:0]      sh_a,
  output logic [3:0]       sh_amt,
  output logic             sh_choice,
  input  logic [15:0]      sh_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [15:0]      work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [15:0]      out_q, out_d;
  logic [15:0]      hold_a_q, hold_a_d;
  logic [3:0]       hold_amt_q, hold_amt_d;
  logic             hold_c_q, hold_c_d;

  logic [3:0]       pass_amt;
  logic             last_pass;

  assign last_pass = (rem_q <= AMT_W'(CHUNK));
  assign pass_amt  = last_pass ? rem_q[3:0] : 4'(CHUNK);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    out_d      = out_q;
    hold_a_d   = hold_a_q;
    hold_amt_d = hold_amt_q;
    hold_c_d   = hold_c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          state_d = S_SHIFT;
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
          if (in_amt >= AMT_W'(16)) begin
            state_d = S_DONE;
            out_d   = '0;
          end
`endif
        end
      end
      S_SHIFT: begin
        work_d     = sh_y;
        rem_d      = rem_q - AMT_W'(pass_amt);
        // Snapshot what the shifter sees so sh_* hold after SHIFT exits.
        hold_a_d   = work_q;
        hold_amt_d = pass_amt;
        hold_c_d   = dir_q;
        if (last_pass) begin
          state_d = S_DONE;
          out_d   = sh_y;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      out_q      <= '0;
      hold_a_q   <= '0;
      hold_amt_q <= '0;
      hold_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      out_q      <= out_d;
      hold_a_q   <= hold_a_d;
      hold_amt_q <= hold_amt_d;
      hold_c_q   <= hold_c_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;
  assign sh_a      = (state_q == S_SHIFT) ? work_q   : hold_a_q;
  assign sh_amt    = (state_q == S_SHIFT) ? pass_amt : hold_amt_q;
  assign sh_choice = (state_q == S_SHIFT) ? dir_q    : hold_c_q;

endmodule

// File: tb/tb_shift_sequencer_16bit.sv
// Self-checking bench: transaction-level model plus directed literal cases and random traffic.
module tb_shift_sequencer_16bit;
  localparam int AMT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic             in_dir = 1'b0;
  logic [15:0]      sh_a;
  logic [3:0]       sh_amt;
  logic             sh_choice;
  logic [15:0]      sh_y;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_data;
  logic             busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  shift_sequencer_16bit #(.AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_choice(sh_choice), .sh_y(sh_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // Stand-in for the combinational barrel shifter.
  assign sh_y = sh_choice ? (sh_a >> sh_amt) : (sh_a << sh_amt);

  always #5 clk = ~clk;

  function automatic logic [15:0] shf(logic [15:0] d, int n, logic dir);
    if (n >= 16) return 16'h0000;
    return dir ? (d >> n) : (d << n);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction model: a request of amount A consumes at most 15 per pass.
  logic        m_busy = 0, m_valid = 0, m_dir = 0, m_shc = 0;
  logic [15:0] m_dat = '0, m_out = '0, m_sha = '0;
  logic [3:0]  m_shamt = '0;
  int          m_amt = 0, m_cons = 0;
  int          m_rem, m_step;
  assign m_rem  = m_amt - m_cons;
  assign m_step = (m_rem > 15) ? 15 : m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_valid <= 0; m_dir <= 0; m_dat <= '0; m_out <= '0;
      m_amt <= 0; m_cons <= 0; m_sha <= '0; m_shamt <= '0; m_shc <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1; m_valid <= 0; m_dat <= in_data; m_amt <= int'(in_amt);
        m_dir <= in_dir; m_cons <= 0;
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
        if (int'(in_amt) >= 16) begin m_valid <= 1; m_out <= '0; end
`endif
      end
    end else if (!m_valid) begin
      m_sha   <= shf(m_dat, m_cons, m_dir);
      m_shamt <= 4'(m_step);
      m_shc   <= m_dir;
      m_cons  <= m_cons + m_step;
      if (m_cons + m_step == m_amt) begin
        m_valid <= 1;
        m_out   <= shf(m_dat, m_amt, m_dir);
      end
    end else if (out_ready) begin
      m_busy <= 0; m_valid <= 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_out);
      if (m_busy && !m_valid) begin
        chk("sh_a", sh_a, shf(m_dat, m_cons, m_dir));
        chk("sh_amt", sh_amt, m_step);
        chk("sh_choice", sh_choice, m_dir);
      end else begin
        chk("sh_a_hold", sh_a, m_sha);
        chk("sh_amt_hold", sh_amt, m_shamt);
        chk("sh_choice_hold", sh_choice, m_shc);
      end
    end
  end

  task automatic directed(string nm, logic [15:0] d, int amt, logic dir,
                          logic [15:0] exp_d, int exp_lat);
    int lat, bcnt;
    in_valid = 1; in_data = d; in_amt = AMT_W'(amt); in_dir = dir; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_data"}, out_data, exp_d);
    @(negedge clk);
    chk({nm, "_busycycles"}, bcnt, exp_lat);
    chk({nm, "_idle"}, in_ready, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 0; out_ready = 1; n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    int n;
    logic [AMT_W-1:0] bnd [6];
    bnd = '{6'd0, 6'd15, 6'd16, 6'd30, 6'd31, 6'd63};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sh_a", sh_a, 0);
    chk("rst_sh_amt", sh_amt, 0);
    chk("rst_sh_choice", sh_choice, 0);
    #2 reset = 0;
    @(negedge clk);

    directed("l1", 16'h8001, 1, 0, 16'h0002, 2);
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
    directed("l20", 16'h0001, 20, 0, 16'h0000, 1);
    directed("l63", 16'hFFFF, 63, 0, 16'h0000, 1);
`else
    directed("l20", 16'h0001, 20, 0, 16'h0000, 3);
    directed("l63", 16'hFFFF, 63, 0, 16'h0000, 6);
`endif
    directed("r14", 16'hF000, 14, 1, 16'h0003, 2);
    directed("a0", 16'h1234, 0, 1, 16'h1234, 2);

    // Backpressure with a competing request held during DONE.
    in_valid = 1; in_data = 16'h8000; in_amt = 6'd15; in_dir = 1; out_ready = 0;
    @(negedge clk);
    in_data = 16'h4321; in_amt = 6'd1; in_dir = 0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 16'h0001);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_next_accepted", busy, 1);
    drain();

    // Asynchronous reset during the second pass of a 40-position shift.
    in_valid = 1; in_data = 16'hABCD; in_amt = 6'd40; in_dir = 0; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    directed("after_rst", 16'h00FF, 4, 0, 16'h0FF0, 2);

    // Random traffic checked by the model every cycle.
    repeat (2500) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 16'($urandom);
      in_amt    = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 5)]
                                               : AMT_W'($urandom_range(0, 63));
      in_dir    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
